// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: IR fields and status in, datapath enables/selects out
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode, funct;
  logic zero, mem_ready;
  logic pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
  logic [1:0] alusrc, pc_src;
  logic alu_a_pc;
  logic [5:0] alu_op;
  logic fault;
  logic [31:0] retired;
  modport master(
    input opcode, funct, zero, mem_ready,
    output pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
    output alusrc, alu_a_pc, pc_src, alu_op, fault, retired
  );
  modport slave(
    output opcode, funct, zero, mem_ready,
    input pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
    input alusrc, alu_a_pc, pc_src, alu_op, fault, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with memory-wait timeout and retire count
module mips_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 16
) (
  input logic clk,
  input logic reset,
  mips_multicycle_ctrl_if.master bus
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT - 1);
  localparam logic [5:0] OP_ADD = 6'b100000, OP_SUB = 6'b100010;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, ADDIEX, ADDIWB, BEQ, JMP, FAULT
  } state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_retired;
  logic w_wait, w_timeout, w_funct_ok, w_retire;
  assign w_funct_ok = bus.funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  assign w_wait = r_state inside {FETCH, MEMRD, MEMWR};
  assign w_timeout = w_wait && !bus.mem_ready && r_cnt == LIM;
  assign w_retire = w_next == FETCH && r_state inside {RTWB, MEMWB, MEMWR, ADDIWB, BEQ, JMP};
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FETCH:  w_next = bus.mem_ready ? DECODE : FETCH;
      DECODE: w_next = bus.opcode == 6'b000000 ? RTEXE :
                       (bus.opcode == 6'b100011 || bus.opcode == 6'b101011) ? MEMADR :
                       bus.opcode == 6'b001000 ? ADDIEX :
                       bus.opcode == 6'b000100 ? BEQ :
                       bus.opcode == 6'b000010 ? JMP : FAULT;
      MEMADR: w_next = bus.opcode == 6'b101011 ? MEMWR : MEMRD;
      MEMRD:  w_next = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:  w_next = bus.mem_ready ? FETCH : MEMWR;
      RTEXE:  w_next = w_funct_ok ? RTWB : FAULT;
      ADDIEX: w_next = ADDIWB;
      MEMWB, RTWB, ADDIWB, BEQ, JMP: w_next = FETCH;
      default: w_next = FAULT;
    endcase
    if (w_timeout) w_next = FAULT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_cnt <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next != r_state) ? '0 : (w_wait && !bus.mem_ready) ? r_cnt + CW'(1) : r_cnt;
      r_retired <= w_retire ? r_retired + 32'd1 : r_retired;
    end
  end
  // enables and requests are held low while reset is asserted
  assign bus.pc_write = !reset && (r_state == FETCH ? bus.mem_ready : r_state == BEQ ? bus.zero : r_state == JMP);
  assign bus.ir_write = !reset && r_state == FETCH && bus.mem_ready;
  assign bus.mem_read = !reset && r_state inside {FETCH, MEMRD};
  assign bus.mem_write = !reset && r_state == MEMWR;
  assign bus.reg_write = !reset && r_state inside {RTWB, MEMWB, ADDIWB};
  assign bus.iord = r_state inside {MEMRD, MEMWR};
  assign bus.reg_dst = r_state == RTWB;
  assign bus.mem_to_reg = r_state == MEMWB;
  assign bus.alusrc = r_state == FETCH ? 2'd1 : r_state == DECODE ? 2'd3 :
                      r_state inside {MEMADR, ADDIEX} ? 2'd2 : 2'd0;
  assign bus.alu_a_pc = r_state inside {FETCH, DECODE};
  assign bus.pc_src = r_state == BEQ ? 2'd1 : r_state == JMP ? 2'd2 : 2'd0;
  assign bus.alu_op = r_state inside {FETCH, DECODE, MEMADR, ADDIEX} ? OP_ADD :
                      r_state == BEQ ? OP_SUB :
                      (r_state == RTEXE && w_funct_ok) ? bus.funct : 6'd0;
  assign bus.fault = r_state == FAULT;
  assign bus.retired = r_retired;
endmodule
